// File: rtl/rom_seq_pkg.sv
// Shared types and default widths for the puzzle ROM sum sequencer.
package rom_seq_pkg;
  localparam int ROM_ADDR_W  = 8;
  localparam int ROM_DATA_W  = 32;
  localparam int ROM_ENTRIES = 204;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rom_seq_state_t;
endpackage

// File: rtl/rom_seq_pipe.sv
// Fixed-depth {valid, data} delay line between ROM output and the accumulator.
module rom_seq_pipe #(
  parameter int DEPTH  = 3,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_vld,
  input  logic [DATA_W-1:0] in_data,
  output logic              tail_vld,
  output logic [DATA_W-1:0] tail_data,
  output logic              any_vld
);
  logic [DEPTH-1:0]             vld_pipe;
  logic [DEPTH-1:0][DATA_W-1:0] data_pipe;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe  <= '0;
      data_pipe <= '0;
    end else begin
      vld_pipe[0]  <= in_vld;
      data_pipe[0] <= in_data;
      for (int i = 1; i < DEPTH; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        data_pipe[i] <= data_pipe[i-1];
      end
    end
  end

  assign tail_vld  = vld_pipe[DEPTH-1];
  assign tail_data = data_pipe[DEPTH-1];

  // The tail is consumed this edge, so only upstream stages keep the run alive.
  always_comb begin
    any_vld = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) any_vld = any_vld | vld_pipe[i];
  end
endmodule

// File: rtl/rom_sum_sequencer.sv
// Sweeps a ROM address window, pipes words to a wide accumulator, pulses done.
// Optional ROM_SEQ_MAX_EN adds a max_word output (largest word summed).
module rom_sum_sequencer
  import rom_seq_pkg::*;
#(
  parameter int ADDR_W     = ROM_ADDR_W,
  parameter int DATA_W     = ROM_DATA_W,
  parameter int ACC_W      = 32,
  parameter int PIPE_DEPTH = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              busy,
  output logic              done,
  output logic [ACC_W-1:0]  result,
`ifdef ROM_SEQ_MAX_EN
  output logic [DATA_W-1:0] max_word,
`endif
  output logic              overflow
);
  rom_seq_state_t    state;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   cnt;
  logic [ACC_W-1:0]  acc;
  logic              tail_vld;
  logic [DATA_W-1:0] tail_data;
  logic              any_vld;
  logic [ACC_W:0]    sum;
  logic              last;

  rom_seq_pipe #(.DEPTH(PIPE_DEPTH), .DATA_W(DATA_W)) u_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_vld    (state == ISSUE),
    .in_data   (rom_data),
    .tail_vld  (tail_vld),
    .tail_data (tail_data),
    .any_vld   (any_vld)
  );

  assign sum  = {1'b0, acc} + {1'b0, ACC_W'(tail_data)};
  assign last = (cnt == len_q - (ADDR_W+1)'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rom_addr <= '0;
      len_q    <= '0;
      cnt      <= '0;
      acc      <= '0;
      overflow <= 1'b0;
    end else begin
      if (tail_vld) begin
        acc <= sum[ACC_W-1:0];
        if (sum[ACC_W]) overflow <= 1'b1;
      end
      case (state)
        IDLE: if (start) begin
          acc      <= '0;
          overflow <= 1'b0;
          if (length != '0) begin
            state    <= ISSUE;
            len_q    <= length;
            cnt      <= '0;
            rom_addr <= base_addr;
          end else begin
            state <= DONE;
          end
        end
        ISSUE: begin
          cnt <= cnt + (ADDR_W+1)'(1);
          // Keep the last issued address on the bus once issue ends.
          if (last) state <= DRAIN;
          else      rom_addr <= rom_addr + ADDR_W'(1);
        end
        DRAIN: if (!any_vld) state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ROM_SEQ_MAX_EN
  always_ff @(posedge clk) begin
    if (rst)                                  max_word <= '0;
    else if (state == IDLE && start)          max_word <= '0;
    else if (tail_vld && tail_data > max_word) max_word <= tail_data;
  end
`endif

  assign busy   = (state == ISSUE) || (state == DRAIN);
  assign done   = (state == DONE);
  assign result = acc;
endmodule

// File: tb/tb_rom_sum_sequencer.sv
// Directed bench for rom_sum_sequencer with a behavioural ROM (data = addr+1).
module tb_rom_sum_sequencer;
  import rom_seq_pkg::*;

`ifdef ROM_SEQ_MAX_EN
  localparam int PD = 1;
`else
  localparam int PD = 3;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  base_addr = '0;
  logic [8:0]  length = '0;
  logic [7:0]  rom_addr;
  logic [31:0] rom_data;
  logic        busy, done, overflow;
  logic [31:0] result;
`ifdef ROM_SEQ_MAX_EN
  logic [31:0] max_word;
`endif
  logic        ovf_mode = 1'b0;
  int          cyc = 0;
  int          total = 0;
  int          passed = 0;

  rom_sum_sequencer #(.ADDR_W(8), .DATA_W(32), .ACC_W(32), .PIPE_DEPTH(PD)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .busy      (busy),
    .done      (done),
    .result    (result),
`ifdef ROM_SEQ_MAX_EN
    .max_word  (max_word),
`endif
    .overflow  (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb rom_data = ovf_mode ? 32'h8000_0000 : {24'b0, rom_addr} + 32'd1;

  // Launches a run and follows it to done; optionally pulses start again at cycle pulse_at.
  task automatic run(input logic [7:0] b, input logic [8:0] l, input int pulse_at,
                     output int lat, output int addr_bad, output int busy_bad);
    int t0;
    logic exp_busy;
    logic [7:0] exp_addr;
    @(negedge clk);
    start = 1'b1; base_addr = b; length = l; t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    lat = -1; addr_bad = 0; busy_bad = 0;
    for (int k = 1; k < 600; k++) begin
      exp_addr = b + 8'(k - 1);
      if (k <= int'(l) && rom_addr !== exp_addr) addr_bad++;
      exp_busy = (l != 0) && (k <= int'(l) + PD);
      if (busy !== exp_busy) busy_bad++;
      if (k == pulse_at) begin
        start = 1'b1; base_addr = 8'd100; length = 9'd50;
      end else begin
        start = 1'b0;
      end
      if (done === 1'b1) begin
        lat = cyc - t0;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    total += 5;
    if (rom_addr !== 8'd0) $display("FAIL reset_rom_addr got %0d want 0", rom_addr); else passed++;
    if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
    if (result !== 32'd0) $display("FAIL reset_result got %0d want 0", result); else passed++;
    if (overflow !== 1'b0) $display("FAIL reset_overflow got %b want 0", overflow); else passed++;
  endtask

  task automatic test_full_sweep();
    int lat, ab, bb;
    run(8'd0, 9'(ROM_ENTRIES), 0, lat, ab, bb);
    total += 5;
    if (result !== 32'd20910) $display("FAIL sweep_result got %0d want 20910", result); else passed++;
    if (overflow !== 1'b0) $display("FAIL sweep_overflow got %b want 0", overflow); else passed++;
    if (lat != ROM_ENTRIES + PD + 1) $display("FAIL sweep_latency got %0d want %0d", lat, ROM_ENTRIES + PD + 1); else passed++;
    if (ab != 0) $display("FAIL sweep_addr got %0d bad want 0", ab); else passed++;
    if (bb != 0) $display("FAIL sweep_busy got %0d bad want 0", bb); else passed++;
  endtask

  task automatic test_wrap();
    int lat, ab, bb;
    run(8'd250, 9'd10, 0, lat, ab, bb);
    total += 3;
    if (result !== 32'd1531) $display("FAIL wrap_result got %0d want 1531", result); else passed++;
    if (ab != 0) $display("FAIL wrap_addr got %0d bad want 0", ab); else passed++;
    if (lat != 10 + PD + 1) $display("FAIL wrap_latency got %0d want %0d", lat, 10 + PD + 1); else passed++;
  endtask

  task automatic test_zero_length();
    int lat, ab, bb;
    run(8'd7, 9'd0, 0, lat, ab, bb);
    total += 3;
    if (lat != 1) $display("FAIL zero_latency got %0d want 1", lat); else passed++;
    if (result !== 32'd0) $display("FAIL zero_result got %0d want 0", result); else passed++;
    if (bb != 0) $display("FAIL zero_busy got %0d bad want 0", bb); else passed++;
  endtask

  task automatic test_overflow();
    int lat, ab, bb;
    ovf_mode = 1'b1;
    run(8'd0, 9'd2, 0, lat, ab, bb);
    ovf_mode = 1'b0;
    total += 4;
    if (result !== 32'd0) $display("FAIL ovf_result got %0d want 0", result); else passed++;
    if (overflow !== 1'b1) $display("FAIL ovf_flag got %b want 1", overflow); else passed++;
    run(8'd0, 9'd4, 0, lat, ab, bb);
    if (result !== 32'd10) $display("FAIL ovf_next_result got %0d want 10", result); else passed++;
    if (overflow !== 1'b0) $display("FAIL ovf_next_flag got %b want 0", overflow); else passed++;
  endtask

  task automatic test_busy_ignore();
    int lat, ab, bb;
    run(8'd0, 9'd4, 2, lat, ab, bb);
    total += 4;
    if (result !== 32'd10) $display("FAIL busy_ign_result got %0d want 10", result); else passed++;
    if (lat != 4 + PD + 1) $display("FAIL busy_ign_latency got %0d want %0d", lat, 4 + PD + 1); else passed++;
    // start held in the done cycle itself must not launch a run
    run(8'd0, 9'd4, 4 + PD + 1, lat, ab, bb);
    if (busy !== 1'b0) $display("FAIL done_ign_busy got %b want 0", busy); else passed++;
    if (result !== 32'd10) $display("FAIL done_ign_result got %0d want 10", result); else passed++;
  endtask

  task automatic test_mid_reset();
    int lat, ab, bb, done_seen;
    @(negedge clk);
    start = 1'b1; base_addr = 8'd0; length = 9'(ROM_ENTRIES);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total += 6;
    if (rom_addr !== 8'd0) $display("FAIL rst_rom_addr got %0d want 0", rom_addr); else passed++;
    if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else passed++;
    if (done !== 1'b0) $display("FAIL rst_done got %b want 0", done); else passed++;
    if (result !== 32'd0) $display("FAIL rst_result got %0d want 0", result); else passed++;
    if (overflow !== 1'b0) $display("FAIL rst_overflow got %b want 0", overflow); else passed++;
    done_seen = 0;
    for (int k = 0; k < 250; k++) begin
      if (done === 1'b1 || busy === 1'b1) done_seen++;
      @(negedge clk);
    end
    if (done_seen != 0) $display("FAIL rst_no_done got %0d active cycles want 0", done_seen); else passed++;
    run(8'd0, 9'd4, 0, lat, ab, bb);
    total += 2;
    if (result !== 32'd10) $display("FAIL rst_rerun_result got %0d want 10", result); else passed++;
    if (lat != 4 + PD + 1) $display("FAIL rst_rerun_latency got %0d want %0d", lat, 4 + PD + 1); else passed++;
  endtask

`ifdef ROM_SEQ_MAX_EN
  task automatic test_max_word();
    int lat, ab, bb;
    run(8'd10, 9'd5, 0, lat, ab, bb);
    total += 3;
    if (max_word !== 32'd15) $display("FAIL max_word got %0d want 15", max_word); else passed++;
    if (result !== 32'd65) $display("FAIL max_result got %0d want 65", result); else passed++;
    if (lat != 7) $display("FAIL max_latency got %0d want 7", lat); else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_full_sweep();
    test_wrap();
    test_zero_length();
    test_overflow();
    test_busy_ignore();
    test_mid_reset();
`ifdef ROM_SEQ_MAX_EN
    test_max_word();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/rom_sum_sequencer.md
# rom_sum_sequencer

Controller that sequences the hardcoded puzzle ROM and its accumulation datapath. On a `start` pulse it sweeps a programmable address window of the combinational ROM and carries a valid bit alongside each word through a fixed-depth register pipeline. It sums the words into a wide accumulator, then reports the result with a one-cycle `done` pulse. It replaces free-running counter-driven accumulation in the day-level top, so a run can be re-launched, resized and observed without a reset.

## Interface
- `ADDR_W`, 8, ROM address width; addresses wrap modulo 2^ADDR_W
- `DATA_W`, 32, ROM word width
- `ACC_W`, 32, accumulator and result width
- `PIPE_DEPTH`, 3, register stages between ROM output and accumulator (legal range 1..8)
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  launch request, sampled only in IDLE
- `base_addr`  in  ADDR_W  first ROM address, latched on accepted start
- `length`  in  ADDR_W+1  number of words to sum, latched on accepted start
- `rom_addr`  out  ADDR_W  address to combinational ROM
- `rom_data`  in  DATA_W  ROM word for `rom_addr`, same cycle
- `busy`  out  1  high from the cycle after an accepted start until `done`
- `done`  out  1  one-cycle pulse, result valid
- `result`  out  ACC_W  sum, held from `done` until the next accepted start
- `overflow`  out  1  sticky: a carry out of the accumulator occurred in this run

## Operation
- Reset values: state IDLE, `rom_addr`=0, `busy`=0, `done`=0, `result`=0, `overflow`=0, all pipeline valids cleared.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE → ISSUE: `start`=1 and `length`≠0. Latch base and length, clear the accumulator and `overflow`, and set the issue count to 0.
- IDLE → DONE: `start`=1 and `length`=0. `result`=0.
- ISSUE:
  - `rom_addr` = base + count (mod 2^ADDR_W).
  - Push {1, `rom_data`} into the pipeline and increment count.
  - When count = length−1 is issued, go to DRAIN.
- DRAIN: push invalid entries and wait until no valid entry remains in any stage. Then go to DONE.
- DONE: `done`=1 for one cycle, `busy`=0, then return to IDLE.
- Accumulator:
  - Adds the pipeline tail word when its valid bit is set.
  - The word is zero-extended to ACC_W+1 and the sum is truncated to ACC_W.
  - The carry bit sets `overflow`.
- `start` while `busy` is ignored, with no queuing. `start` in the DONE cycle is also ignored.
- `rst` mid-run returns everything to reset values on the next edge. No `done` is produced for the aborted run.

## Timing
- Start sampled in IDLE at cycle T: the word at index i is presented on `rom_addr` in cycle T+1+i.
- That word is added at the end of cycle T+1+i+PIPE_DEPTH.
- `done` is high in cycle T+L+PIPE_DEPTH+1. Start-to-done is L+PIPE_DEPTH+1 cycles.
- For L=0, `done` is high in cycle T+1.
- `busy` is high in cycles T+1 .. T+L+PIPE_DEPTH and low in the `done` cycle.
- `result` and `overflow` are stable from the `done` cycle until the cycle after the next accepted start.
- Back-to-back runs: the earliest next accepted start is the first IDLE cycle after `done`.
- `rom_addr` holds its last value outside ISSUE.

## Configuration
- `ROM_SEQ_MAX_EN`
  - Defined: adds output `max_word` [DATA_W], the unsigned maximum of the words summed in the run. It is cleared on accepted start, updated at the pipeline tail, and valid with `done`. It is 0 for L=0 and 0 on reset.
  - Undefined: the port and its logic are absent, and all other behaviour is identical.

## Structure
- Package `rom_seq_pkg`:
  - state enum `rom_seq_state_t` (IDLE, ISSUE, DRAIN, DONE)
  - default width constants `ROM_ADDR_W`=8, `ROM_DATA_W`=32
  - day-3 entry count `ROM_ENTRIES`=204
- Sub-module `rom_seq_pipe`: PIPE_DEPTH-stage delay line of {valid, data}. It is synchronously cleared by `rst` and exposes the tail valid/data plus an any-valid flag for DRAIN exit.

## Test plan
Bench ROM model: data = addr+1 unless stated otherwise; PIPE_DEPTH=3 unless stated otherwise.
- Full sweep: base=0, length=204 → `result`=20910, `overflow`=0, `done` exactly 208 cycles after the start cycle.
- Wrap: base=250, length=10 → addresses 250..255,0..3 issued in order, `result`=1531.
- Zero length: length=0 → `done` at T+1, `result`=0, `busy` never high.
- Overflow: ROM model returns 0x80000000 for every address, length=2 → `result`=0, `overflow`=1. A following run with the normal model, base=0, length=4, gives `result`=10, `overflow`=0.
- Busy and reset handling:
  - `start` pulsed during a run (base=0, length=4) → ignored, `result`=10.
  - `rst` asserted 3 cycles into a length=204 run → all outputs return to reset values and no `done` appears.
  - A new run then completes correctly.
- With `ROM_SEQ_MAX_EN` defined and PIPE_DEPTH=1: base=10, length=5 → `max_word`=15, `result`=65, `done` 7 cycles after start.
